// File: rtl/m4_coef_loader_pkg.sv
// rtl/m4_coef_loader_pkg.sv - shared constants and FSM encoding for the coefficient loader
package m4_pkg;

    localparam int              COEF_W = 13;
    localparam logic [12:0]     UNITY  = 13'h1000;
    localparam int              N_COEF = 9;
    localparam int              ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Diagonal entries of the 3x3 matrix (row-major) reset to 1.0
    function automatic logic is_diag(input int idx);
        return (idx == 0) || (idx == 4) || (idx == 8);
    endfunction

endpackage

// File: rtl/m4_coef_loader_if.sv
// rtl/m4_coef_loader_if.sv - host write port, vblank input and active coefficient bus
interface m4_coef_loader_if #(
    parameter int COEF_W = m4_pkg::COEF_W
);
    logic                      WE;
    logic [m4_pkg::ADDR_W-1:0] WADDR;
    logic [COEF_W-1:0]         WDATA;
    logic                      LOAD_REQ;
    logic                      OVP;
    logic [COEF_W-1:0]         CF0D, CF1D, CF2D, CF3D, CF4D, CF5D, CF6D, CF7D, CF8D;
    logic                      ARMED;
    logic                      DONE;
    logic                      WERR;

    modport master (
        output WE, WADDR, WDATA, LOAD_REQ, OVP,
        input  CF0D, CF1D, CF2D, CF3D, CF4D, CF5D, CF6D, CF7D, CF8D,
        input  ARMED, DONE, WERR
    );

    modport slave (
        input  WE, WADDR, WDATA, LOAD_REQ, OVP,
        output CF0D, CF1D, CF2D, CF3D, CF4D, CF5D, CF6D, CF7D, CF8D,
        output ARMED, DONE, WERR
    );
endinterface

// File: rtl/m4_coef_loader_ovp_edge.sv
// rtl/m4_coef_loader_ovp_edge.sv - registers vertical-blank level and flags its rising edge
module m4_ovp_edge (
    input  logic CLK,
    input  logic RST,
    input  logic ovp,
    output logic rise
);
    logic ovp_q;
    logic primed;

    // primed keeps a level that is already high when reset releases from looking like an edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovp_q  <= 1'b0;
            primed <= 1'b0;
        end else begin
            ovp_q  <= ovp;
            primed <= 1'b1;
        end
    end

    assign rise = ovp & ~ovp_q & primed;
endmodule

// File: rtl/m4_coef_loader.sv
// rtl/m4_coef_loader.sv - double-buffered 3x3 coefficient bank committed on vertical blank
module m4_coef_loader #(
    parameter int                COEF_W = m4_pkg::COEF_W,
    parameter logic [COEF_W-1:0] UNITY  = m4_pkg::UNITY
) (
    input  logic           CLK,
    input  logic           RST,
    m4_coef_loader_if.slave bus
);
    import m4_pkg::*;

    logic [COEF_W-1:0] sh  [N_COEF];
    logic [COEF_W-1:0] act [N_COEF];
    logic [N_COEF-1:0] mask;
    state_t            state;
    logic              armed_q;
    logic              done_q;
    logic              werr_q;

    logic              ovp_rise;
    logic              wr_ok;
    logic              wr_bad;
    logic [N_COEF-1:0] wr_bit;
    logic              load_accept;
    logic              load_reject;
    logic              commit_now;

    function automatic logic [COEF_W-1:0] ident(input int idx);
        return is_diag(idx) ? UNITY : '0;
    endfunction

    m4_ovp_edge u_ovp_edge (
        .CLK  (CLK),
        .RST  (RST),
        .ovp  (bus.OVP),
        .rise (ovp_rise)
    );

    assign wr_ok       = bus.WE && (bus.WADDR < ADDR_W'(N_COEF));
    assign wr_bad      = bus.WE && !wr_ok;
    assign wr_bit      = wr_ok ? ({{(N_COEF-1){1'b0}}, 1'b1} << bus.WADDR) : '0;
    assign load_accept = (state == ST_IDLE) && bus.LOAD_REQ && (&mask);
    assign load_reject = (state == ST_IDLE) && bus.LOAD_REQ && !(&mask);
    assign commit_now  = (state == ST_ARMED) && ovp_rise;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_COEF; i++) begin
                sh[i]  <= ident(i);
                act[i] <= ident(i);
            end
            mask    <= '0;
            state   <= ST_IDLE;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_accept) begin
                        state   <= ST_ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (commit_now) begin
                        state   <= ST_COMMIT;
                        armed_q <= 1'b0;
                        done_q  <= 1'b1;
                        // Whole bank moves in one edge; a same-cycle write lands after the copy
                        for (int i = 0; i < N_COEF; i++) begin
                            act[i] <= sh[i];
                        end
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    armed_q <= 1'b0;
                end
            endcase

            if (wr_ok) begin
                sh[bus.WADDR] <= bus.WDATA;
            end

            mask <= commit_now ? wr_bit : (mask | wr_bit);

            if (load_accept) begin
                werr_q <= 1'b0;
            end
            if (wr_bad || load_reject) begin
                werr_q <= 1'b1;
            end
        end
    end

    assign bus.CF0D  = act[0];
    assign bus.CF1D  = act[1];
    assign bus.CF2D  = act[2];
    assign bus.CF3D  = act[3];
    assign bus.CF4D  = act[4];
    assign bus.CF5D  = act[5];
    assign bus.CF6D  = act[6];
    assign bus.CF7D  = act[7];
    assign bus.CF8D  = act[8];
    assign bus.ARMED = armed_q;
    assign bus.DONE  = done_q;
    assign bus.WERR  = werr_q;
endmodule

// File: tb/tb_m4_coef_loader.sv
// tb/tb_m4_coef_loader.sv - directed self-checking bench for the coefficient loader
module tb_m4_coef_loader;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    m4_coef_loader_if #(.COEF_W(13)) bus ();

    m4_coef_loader #(.COEF_W(13), .UNITY(13'h1000)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] cf(input int i);
        case (i)
            0: return bus.CF0D;
            1: return bus.CF1D;
            2: return bus.CF2D;
            3: return bus.CF3D;
            4: return bus.CF4D;
            5: return bus.CF5D;
            6: return bus.CF6D;
            7: return bus.CF7D;
            8: return bus.CF8D;
            default: return 'x;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [12:0] d);
        bus.WE    = 1'b1;
        bus.WADDR = a;
        bus.WDATA = d;
        tick();
        bus.WE    = 1'b0;
    endtask

    task automatic load();
        bus.LOAD_REQ = 1'b1;
        tick();
        bus.LOAD_REQ = 1'b0;
    endtask

    task automatic chk_bank(input string tag, input logic [12:0] base);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_cf%0d", tag, i), {3'b0, cf(i)}, {3'b0, base + 13'(i)});
        end
    endtask

    task automatic chk_identity(input string tag);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_cf%0d", tag, i), {3'b0, cf(i)},
                (i == 0 || i == 4 || i == 8) ? 16'h1000 : 16'h0000);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.WE       = 1'b0;
        bus.WADDR    = '0;
        bus.WDATA    = '0;
        bus.LOAD_REQ = 1'b0;
        bus.OVP      = 1'b0;
        tick();
        tick();
        chk_identity("reset");
        chk("reset_armed", {15'b0, bus.ARMED}, 16'h0);
        chk("reset_werr",  {15'b0, bus.WERR},  16'h0);
        chk("reset_done",  {15'b0, bus.DONE},  16'h0);
        rst = 1'b0;
        tick();

        // Basic full load and commit
        for (int i = 0; i < 9; i++) wr(4'(i), 13'h0100 + 13'(i));
        load();
        chk("t1_armed0", {15'b0, bus.ARMED}, 16'h1);
        tick();
        chk("t1_armed1", {15'b0, bus.ARMED}, 16'h1);
        chk("t1_hold_cf0", {3'b0, cf(0)}, 16'h1000);
        bus.OVP = 1'b1;
        tick();
        chk("t1_done", {15'b0, bus.DONE}, 16'h1);
        chk("t1_armed_off", {15'b0, bus.ARMED}, 16'h0);
        chk_bank("t1", 13'h0100);
        tick();
        chk("t1_done_off", {15'b0, bus.DONE}, 16'h0);
        bus.OVP = 1'b0;
        tick();

        // Incomplete mask rejects the load
        for (int i = 0; i < 8; i++) wr(4'(i), 13'h0200 + 13'(i));
        load();
        chk("t2_armed", {15'b0, bus.ARMED}, 16'h0);
        chk("t2_werr",  {15'b0, bus.WERR},  16'h1);
        bus.OVP = 1'b1;
        tick();
        bus.OVP = 1'b0;
        tick();
        chk("t2_done", {15'b0, bus.DONE}, 16'h0);
        chk("t2_cf0", {3'b0, cf(0)}, 16'h0100);
        chk("t2_cf7", {3'b0, cf(7)}, 16'h0107);

        // OVP already high at arming needs a fresh rising edge
        bus.OVP = 1'b1;
        tick();
        wr(4'd8, 13'h0208);
        load();
        chk("t3_werr_clr", {15'b0, bus.WERR},  16'h0);
        chk("t3_armed",    {15'b0, bus.ARMED}, 16'h1);
        tick();
        tick();
        chk("t3_armed_hold", {15'b0, bus.ARMED}, 16'h1);
        chk("t3_no_done",    {15'b0, bus.DONE},  16'h0);
        chk("t3_hold_cf0",   {3'b0, cf(0)},      16'h0100);
        bus.OVP = 1'b0;
        tick();
        chk("t3_armed_low", {15'b0, bus.ARMED}, 16'h1);
        bus.OVP = 1'b1;
        tick();
        chk("t3_done", {15'b0, bus.DONE}, 16'h1);
        chk_bank("t3", 13'h0200);
        tick();
        bus.OVP = 1'b0;
        tick();

        // Write on the commit edge: copy sees old value, write survives for next load
        for (int i = 0; i < 9; i++) wr(4'(i), 13'h0300 + 13'(i));
        load();
        chk("t4_armed", {15'b0, bus.ARMED}, 16'h1);
        bus.OVP   = 1'b1;
        bus.WE    = 1'b1;
        bus.WADDR = 4'd3;
        bus.WDATA = 13'h1FFF;
        tick();
        bus.WE = 1'b0;
        chk("t4_done", {15'b0, bus.DONE}, 16'h1);
        chk("t4_cf3_old", {3'b0, cf(3)}, 16'h0303);
        chk("t4_cf4", {3'b0, cf(4)}, 16'h0304);
        bus.OVP = 1'b0;
        tick();
        load();
        chk("t4_partial_werr",  {15'b0, bus.WERR},  16'h1);
        chk("t4_partial_armed", {15'b0, bus.ARMED}, 16'h0);
        for (int i = 0; i < 9; i++) if (i != 3) wr(4'(i), 13'h0400 + 13'(i));
        load();
        chk("t4_rearm", {15'b0, bus.ARMED}, 16'h1);
        chk("t4_werr_clr", {15'b0, bus.WERR}, 16'h0);
        bus.OVP = 1'b1;
        tick();
        chk("t4_cf3_new", {3'b0, cf(3)}, 16'h1FFF);
        chk("t4_cf0", {3'b0, cf(0)}, 16'h0400);
        chk("t4_cf8", {3'b0, cf(8)}, 16'h0408);
        bus.OVP = 1'b0;
        tick();

        // Out-of-range address flags an error and leaves the shadow alone
        for (int i = 0; i < 9; i++) wr(4'(i), 13'h0500 + 13'(i));
        wr(4'd12, 13'h0AAA);
        chk("t5_werr",  {15'b0, bus.WERR},  16'h1);
        chk("t5_armed", {15'b0, bus.ARMED}, 16'h0);
        load();
        chk("t5_werr_clr", {15'b0, bus.WERR},  16'h0);
        chk("t5_armed1",   {15'b0, bus.ARMED}, 16'h1);
        bus.OVP = 1'b1;
        tick();
        chk("t5_done", {15'b0, bus.DONE}, 16'h1);
        chk_bank("t5", 13'h0500);
        bus.OVP = 1'b0;
        tick();

        // Asynchronous reset while armed discards the pending commit
        for (int i = 0; i < 9; i++) wr(4'(i), 13'h0600 + 13'(i));
        load();
        chk("t6_armed", {15'b0, bus.ARMED}, 16'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_identity("t6_async");
        chk("t6_armed_rst", {15'b0, bus.ARMED}, 16'h0);
        tick();
        rst = 1'b0;
        tick();
        bus.OVP = 1'b1;
        tick();
        chk("t6_no_done",  {15'b0, bus.DONE},  16'h0);
        chk("t6_armed_off", {15'b0, bus.ARMED}, 16'h0);
        chk_identity("t6_after");
        bus.OVP = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/m4_coef_loader.md
M4_COEF_LOADER -- requirements
Module: m4_coef_loader

Interface
REQ-001 Parameter: COEF_W, 13, coefficient width in bits.
REQ-002 Parameter: UNITY, 13'h1000, reset value of diagonal coefficients (1.0, 12 fractional bits).
REQ-003 CLK  input  1  sole clock; all state on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 WE  input  1  host write strobe, one write per asserted cycle.
REQ-006 WADDR  input  4  coefficient index 0..8.
REQ-007 WDATA  input  COEF_W  coefficient value.
REQ-008 LOAD_REQ  input  1  single-cycle pulse; arms a commit.
REQ-009 OVP  input  1  vertical-blank level from timing generator.
REQ-010 CF0D..CF8D  output  COEF_W each  active coefficients to matrix multiplier; registered.
REQ-011 ARMED  output  1  commit pending.
REQ-012 DONE  output  1  one-cycle pulse on commit.
REQ-013 WERR  output  1  sticky error flag; cleared by reset or by a LOAD_REQ that is accepted.

Function
REQ-014 Shadow bank: nine COEF_W registers SH0..SH8; WE with WADDR<=8 writes WDATA to SH[WADDR] next edge.
REQ-015 WE with WADDR>8: no shadow change; WERR set.
REQ-016 Written mask: 9-bit, bit set on each valid shadow write; cleared on commit.
REQ-017 FSM states: IDLE, ARMED, COMMIT.
REQ-018 IDLE->ARMED on LOAD_REQ when mask is all ones; LOAD_REQ with incomplete mask is ignored and sets WERR.
REQ-019 ARMED->COMMIT on OVP rising edge (OVP=1 this cycle, 0 previous cycle); OVP held high at arming does not trigger; next rising edge is required.
REQ-020 COMMIT: CF0D..CF8D <= SH0..SH8 at that edge; DONE=1 for exactly that cycle; next state IDLE; mask cleared.
REQ-021 Latency: CFxD updates on the edge following the cycle OVP rise is sampled; DONE coincides with the first cycle new values are visible.
REQ-022 ARMED output = 1 in state ARMED only.
REQ-023 Writes in ARMED are accepted; the commit uses the latest shadow contents.
REQ-024 A write in the same cycle the copy occurs: the copy takes the pre-write shadow value; the write lands in shadow and sets its mask bit after the clear.
REQ-025 LOAD_REQ in ARMED or COMMIT: ignored, no error.
REQ-026 CFxD outputs change only in COMMIT; never partially updated.
REQ-027 Values pass unmodified; sign interpretation (diagonal unsigned, off-diagonal two's complement) belongs to the consumer.

Reset
REQ-028 RST asserted: CF0D, CF4D, CF8D = UNITY; all other CFxD = 0; shadow bank equals the same identity set; mask=0; FSM=IDLE; ARMED=0, DONE=0, WERR=0; OVP edge register=0.
REQ-029 RST during ARMED or COMMIT: pending commit discarded; outputs revert to identity asynchronously.
REQ-030 After deassertion, an OVP already high is not an edge.

Structure
REQ-031 Shared package m4_pkg: COEF_W, UNITY, FSM state encoding, coefficient count (9).
REQ-032 One sub-module, m4_ovp_edge: registers OVP and emits the rising-edge pulse.
REQ-033 Otherwise flat; shadow and active banks are arrays indexed 0..8.

Verification
REQ-034 Reset -> CF0D=CF4D=CF8D=0x1000; others 0; ARMED=0; WERR=0.
REQ-035 Write addresses 0..8 with values 0x0100..0x0108, LOAD_REQ, OVP 0->1 -> ARMED=1 until the edge; CF0D..CF8D=0x0100..0x0108 and DONE=1 one cycle later, then ARMED=0.
REQ-036 Write addresses 0..7 only, LOAD_REQ -> stays IDLE; WERR=1; outputs unchanged after OVP toggles.
REQ-037 Full load; OVP already high at LOAD_REQ -> no commit until OVP falls and rises again.
REQ-038 ARMED; write SH3=0x1FFF on the commit edge -> CF3D=old shadow value; next full load plus commit carries 0x1FFF.
REQ-039 WE with WADDR=12 -> WERR=1; shadow unchanged; RST mid-ARMED -> identity outputs; no DONE.
